// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle controller: states, opcodes,
// function codes, ALU control codes and datapath mux selects.
package mc_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned ALUC_W  = 4;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTYPEEX, S_ALUWB, S_BRANCH, S_IMMEX, S_IMMWB,
        S_JUMP, S_JAL, S_JR
    } state_e;

    // Which rule the ALU decoder applies this state.
    typedef enum logic [1:0] {
        ALU_CLS_ADD, ALU_CLS_SUB, ALU_CLS_FUNCT, ALU_CLS_IMM
    } alu_cls_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LB    = 6'b100000;
    localparam logic [OP_W-1:0] OP_LH    = 6'b100001;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_LBU   = 6'b100100;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    localparam logic [OP_W-1:0] FN_SLL   = 6'b000000;
    localparam logic [OP_W-1:0] FN_SRL   = 6'b000010;
    localparam logic [OP_W-1:0] FN_JR    = 6'b001000;
    localparam logic [OP_W-1:0] FN_ADD   = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB   = 6'b100010;
    localparam logic [OP_W-1:0] FN_AND   = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR    = 6'b100101;
    localparam logic [OP_W-1:0] FN_SLT   = 6'b101010;

    localparam logic [ALUC_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALUC_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALUC_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALUC_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALUC_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALUC_W-1:0] ALU_SLL = 4'b1000;
    localparam logic [ALUC_W-1:0] ALU_SRL = 4'b1001;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    function automatic logic is_mem_state(state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

    // R-type functs that execute through RTYPEEX (jr is handled separately).
    function automatic logic is_alu_funct(logic [OP_W-1:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) || (f == FN_OR) ||
               (f == FN_SLT) || (f == FN_SLL) || (f == FN_SRL);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and status in, control strobes out.
interface mc_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       pcen;
    logic       irwrite;
    logic       iord;
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
    logic       regdst;
    logic       link;
    logic       lbu;
    logic       half;
    logic       b;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [1:0] pcsrc;
    logic [3:0] alucontrol;
    logic       mem_timeout;
    logic       illegal;

    modport master (
        input  op, funct, zero, mem_ready,
        output pcen, irwrite, iord, memwrite, regwrite, memtoreg, regdst, link,
               lbu, half, b, alusrca, alusrcb, zeroext, pcsrc, alucontrol,
               mem_timeout, illegal
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  pcen, irwrite, iord, memwrite, regwrite, memtoreg, regdst, link,
               lbu, half, b, alusrca, alusrcb, zeroext, pcsrc, alucontrol,
               mem_timeout, illegal
    );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU control: fixed ADD/SUB, or derived from funct (R-type) or op (immediate).
module alu_decoder
    import mc_pkg::*;
(
    input  alu_cls_e          cls,
    input  logic [OP_W-1:0]   op,
    input  logic [OP_W-1:0]   funct,
    output logic [ALUC_W-1:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (cls)
            ALU_CLS_SUB: alucontrol = ALU_SUB;
            ALU_CLS_FUNCT: begin
                case (funct)
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    FN_SLL:  alucontrol = ALU_SLL;
                    FN_SRL:  alucontrol = ALU_SRL;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            ALU_CLS_IMM: begin
                case (op)
                    OP_ANDI: alucontrol = ALU_AND;
                    OP_ORI:  alucontrol = ALU_OR;
                    OP_SLTI: alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the shared-memory multicycle datapath, with a
// mem_ready stall handshake and a per-memory-state wait timeout.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 255
)
(
    input  logic clk,
    input  logic reset,
    mc_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    // Timeout fires on the WAIT_LIMIT-th consecutive not-ready cycle of a memory state.
    localparam logic [CNT_W-1:0] TIMEOUT_AT = CNT_W'(WAIT_LIMIT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    alu_cls_e         alu_cls;
    logic             in_mem;
    logic             timeout;

    assign in_mem  = is_mem_state(state_q);
    assign timeout = in_mem && !bus.mem_ready && (wait_cnt_q == TIMEOUT_AT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Counter runs only while stalled in a memory state; any exit or entry clears it.
    always_comb begin
        wait_cnt_d = '0;
        if (in_mem && !bus.mem_ready && !timeout) begin
            wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d         = state_q;
        alu_cls         = ALU_CLS_ADD;
        bus.pcen        = 1'b0;
        bus.irwrite     = 1'b0;
        bus.iord        = 1'b0;
        bus.memwrite    = 1'b0;
        bus.regwrite    = 1'b0;
        bus.memtoreg    = 1'b0;
        bus.regdst      = 1'b0;
        bus.link        = 1'b0;
        bus.lbu         = 1'b0;
        bus.half        = 1'b0;
        bus.b           = 1'b0;
        bus.alusrca     = 1'b0;
        bus.alusrcb     = SRCB_RT;
        bus.zeroext     = 1'b0;
        bus.pcsrc       = PCSRC_ALU;
        bus.mem_timeout = timeout;
        bus.illegal     = 1'b0;

        case (state_q)
            S_FETCH: begin
                bus.alusrcb = SRCB_FOUR;
                bus.irwrite = bus.mem_ready;
                bus.pcen    = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                bus.alusrcb = SRCB_IMM_SH2;
                case (bus.op)
                    OP_LW, OP_LB, OP_LBU, OP_LH, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (bus.funct == FN_JR)            state_d = S_JR;
                        else if (is_alu_funct(bus.funct))  state_d = S_RTYPEEX;
                        else begin
                            state_d     = S_FETCH;
                            bus.illegal = 1'b1;
                        end
                    end
                    OP_BEQ, OP_BNE:                     state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  state_d = S_IMMEX;
                    OP_J:                               state_d = S_JUMP;
                    OP_JAL:                             state_d = S_JAL;
                    default: begin
                        state_d     = S_FETCH;
                        bus.illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = SRCB_IMM;
                state_d     = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.iord = 1'b1;
                bus.lbu  = (bus.op == OP_LBU);
                bus.half = (bus.op == OP_LH);
                bus.b    = (bus.op == OP_LB);
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                bus.regwrite = 1'b1;
                bus.memtoreg = 1'b1;
                bus.lbu      = (bus.op == OP_LBU);
                bus.half     = (bus.op == OP_LH);
                bus.b        = (bus.op == OP_LB);
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_RTYPEEX: begin
                bus.alusrca = 1'b1;
                alu_cls     = ALU_CLS_FUNCT;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                bus.regwrite = 1'b1;
                bus.regdst   = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                bus.alusrca = 1'b1;
                alu_cls     = ALU_CLS_SUB;
                bus.pcsrc   = PCSRC_ALUOUT;
                bus.pcen    = bus.zero ^ (bus.op == OP_BNE);
                state_d     = S_FETCH;
            end
            S_IMMEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = SRCB_IMM;
                bus.zeroext = (bus.op == OP_ANDI) || (bus.op == OP_ORI);
                alu_cls     = ALU_CLS_IMM;
                state_d     = S_IMMWB;
            end
            S_IMMWB: begin
                bus.regwrite = 1'b1;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                bus.pcsrc = PCSRC_JUMP;
                bus.pcen  = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                bus.pcsrc    = PCSRC_JUMP;
                bus.pcen     = 1'b1;
                bus.regwrite = 1'b1;
                bus.link     = 1'b1;
                state_d      = S_FETCH;
            end
            S_JR: begin
                bus.pcsrc = PCSRC_RS;
                bus.pcen  = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        if (timeout) state_d = S_FETCH;

        // Write enables stay low for the whole reset assertion, including the FETCH decode.
        if (reset) begin
            bus.pcen     = 1'b0;
            bus.irwrite  = 1'b0;
            bus.memwrite = 1'b0;
            bus.regwrite = 1'b0;
        end
    end

    alu_decoder u_alu_decoder (
        .cls        (alu_cls),
        .op         (bus.op),
        .funct      (bus.funct),
        .alucontrol (bus.alucontrol)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle state and full control-vector checks.
module tb_multicycle_controller;
    import mc_pkg::*;

    localparam int unsigned WL = 6;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    mc_if bus();

    multicycle_controller #(.WAIT_LIMIT(WL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control vector layout: pcen irwrite iord memwrite regwrite memtoreg regdst link
    // lbu half b | alusrca | alusrcb[1:0] | zeroext | pcsrc[1:0] | alucontrol[3:0] | tmo | ill
    localparam logic [22:0] E_PCEN = 23'(1) << 22;
    localparam logic [22:0] E_IRW  = 23'(1) << 21;
    localparam logic [22:0] E_IORD = 23'(1) << 20;
    localparam logic [22:0] E_MEMW = 23'(1) << 19;
    localparam logic [22:0] E_REGW = 23'(1) << 18;
    localparam logic [22:0] E_M2R  = 23'(1) << 17;
    localparam logic [22:0] E_RDST = 23'(1) << 16;
    localparam logic [22:0] E_LINK = 23'(1) << 15;
    localparam logic [22:0] E_LBU  = 23'(1) << 14;
    localparam logic [22:0] E_HALF = 23'(1) << 13;
    localparam logic [22:0] E_B    = 23'(1) << 12;
    localparam logic [22:0] E_SRCA = 23'(1) << 11;
    localparam logic [22:0] E_ZEXT = 23'(1) << 8;
    localparam logic [22:0] E_TMO  = 23'(1) << 1;
    localparam logic [22:0] E_ILL  = 23'(1);

    function automatic logic [22:0] srcb(input logic [1:0] v);
        return 23'(v) << 9;
    endfunction
    function automatic logic [22:0] psrc(input logic [1:0] v);
        return 23'(v) << 6;
    endfunction
    function automatic logic [22:0] aluc(input logic [3:0] v);
        return 23'(v) << 2;
    endfunction

    function automatic logic [22:0] ctl_vec();
        return {bus.pcen, bus.irwrite, bus.iord, bus.memwrite, bus.regwrite, bus.memtoreg,
                bus.regdst, bus.link, bus.lbu, bus.half, bus.b, bus.alusrca, bus.alusrcb,
                bus.zeroext, bus.pcsrc, bus.alucontrol, bus.mem_timeout, bus.illegal};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Check the current cycle, then advance to just after the next rising edge.
    task automatic step(input string tag, input state_e st, input logic [22:0] e);
        #1;
        check({tag, "/state"}, 32'(dut.state_q), 32'(st));
        check({tag, "/ctl"}, 32'(ctl_vec()), 32'(e));
        @(posedge clk);
        #1;
    endtask

    logic [22:0] fetch_ok, fetch_wait, dec;

    task automatic begin_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                               input logic z);
        bus.op        = op;
        bus.funct     = fn;
        bus.zero      = z;
        bus.mem_ready = 1'b1;
        step({tag, ".fetch"}, S_FETCH, fetch_ok);
        step({tag, ".decode"}, S_DECODE, dec);
    endtask

    task automatic load(input string tag, input logic [5:0] op, input logic [22:0] width);
        begin_instr(tag, op, 6'b000000, 1'b0);
        step({tag, ".memadr"}, S_MEMADR, E_SRCA | srcb(2'b10) | aluc(4'b0010));
        step({tag, ".memrd"}, S_MEMRD, E_IORD | width | aluc(4'b0010));
        step({tag, ".memwb"}, S_MEMWB, E_REGW | E_M2R | width | aluc(4'b0010));
    endtask

    task automatic rtype(input string tag, input logic [5:0] fn, input logic [3:0] ac);
        begin_instr(tag, 6'b000000, fn, 1'b0);
        step({tag, ".ex"}, S_RTYPEEX, E_SRCA | srcb(2'b00) | aluc(ac));
        step({tag, ".wb"}, S_ALUWB, E_REGW | E_RDST | aluc(4'b0010));
    endtask

    task automatic branch(input string tag, input logic [5:0] op, input logic z,
                          input logic [22:0] pc);
        begin_instr(tag, op, 6'b000000, z);
        step({tag, ".br"}, S_BRANCH, pc | E_SRCA | psrc(2'b01) | aluc(4'b0110));
    endtask

    task automatic imm(input string tag, input logic [5:0] op, input logic [22:0] zx,
                       input logic [3:0] ac);
        begin_instr(tag, op, 6'b000000, 1'b0);
        step({tag, ".ex"}, S_IMMEX, E_SRCA | srcb(2'b10) | zx | aluc(ac));
        step({tag, ".wb"}, S_IMMWB, E_REGW | aluc(4'b0010));
    endtask

    initial begin
        n_chk      = 0;
        n_err      = 0;
        fetch_ok   = E_PCEN | E_IRW | srcb(2'b01) | aluc(4'b0010);
        fetch_wait = srcb(2'b01) | aluc(4'b0010);
        dec        = srcb(2'b11) | aluc(4'b0010);

        reset         = 1'b1;
        bus.op        = 6'b100011;
        bus.funct     = 6'b000000;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        #12;
        check("rst/state", 32'(dut.state_q), 32'(S_FETCH));
        check("rst/cnt", 32'(dut.wait_cnt_q), 32'd0);
        check("rst/ctl", 32'(ctl_vec()), 32'(fetch_wait));
        @(negedge clk);
        reset = 1'b0;

        load("lw", 6'b100011, 23'd0);
        load("lbu", 6'b100100, E_LBU);
        load("lh", 6'b100001, E_HALF);
        load("lb", 6'b100000, E_B);

        // sw preceded by a two-cycle fetch stall, then three write wait states.
        bus.op        = 6'b101011;
        bus.mem_ready = 1'b0;
        step("sw.fwait0", S_FETCH, fetch_wait);
        step("sw.fwait1", S_FETCH, fetch_wait);
        bus.mem_ready = 1'b1;
        step("sw.fetch", S_FETCH, fetch_ok);
        step("sw.decode", S_DECODE, dec);
        step("sw.memadr", S_MEMADR, E_SRCA | srcb(2'b10) | aluc(4'b0010));
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step($sformatf("sw.wwait%0d", i), S_MEMWR,
                                         E_IORD | E_MEMW | aluc(4'b0010));
        bus.mem_ready = 1'b1;
        step("sw.wdone", S_MEMWR, E_IORD | E_MEMW | aluc(4'b0010));

        rtype("sub", 6'b100010, 4'b0110);
        rtype("slt", 6'b101010, 4'b0111);
        rtype("sll", 6'b000000, 4'b1000);
        rtype("srl", 6'b000010, 4'b1001);
        rtype("or",  6'b100101, 4'b0001);

        begin_instr("jr", 6'b000000, 6'b001000, 1'b0);
        step("jr.exec", S_JR, E_PCEN | psrc(2'b11) | aluc(4'b0010));

        branch("beq1", 6'b000100, 1'b1, E_PCEN);
        branch("beq0", 6'b000100, 1'b0, 23'd0);
        branch("bne1", 6'b000101, 1'b1, 23'd0);
        branch("bne0", 6'b000101, 1'b0, E_PCEN);

        imm("andi", 6'b001100, E_ZEXT, 4'b0000);
        imm("ori",  6'b001101, E_ZEXT, 4'b0001);
        imm("addi", 6'b001000, 23'd0,  4'b0010);
        imm("slti", 6'b001010, 23'd0,  4'b0111);

        begin_instr("j", 6'b000010, 6'b000000, 1'b0);
        step("j.exec", S_JUMP, E_PCEN | psrc(2'b10) | aluc(4'b0010));
        begin_instr("jal", 6'b000011, 6'b000000, 1'b0);
        step("jal.exec", S_JAL, E_PCEN | E_REGW | E_LINK | psrc(2'b10) | aluc(4'b0010));

        // Illegal opcode and illegal R-type funct both return straight to FETCH.
        bus.op = 6'b111111;
        step("ill.fetch", S_FETCH, fetch_ok);
        step("ill.decode", S_DECODE, dec | E_ILL);
        bus.op    = 6'b000000;
        bus.funct = 6'b111111;
        step("illfn.fetch", S_FETCH, fetch_ok);
        step("illfn.decode", S_DECODE, dec | E_ILL);

        // Read stall reaching the wait limit.
        begin_instr("tmo", 6'b100011, 6'b000000, 1'b0);
        step("tmo.memadr", S_MEMADR, E_SRCA | srcb(2'b10) | aluc(4'b0010));
        bus.mem_ready = 1'b0;
        for (int i = 0; i < int'(WL) - 1; i++) step($sformatf("tmo.wait%0d", i), S_MEMRD,
                                                     E_IORD | aluc(4'b0010));
        step("tmo.pulse", S_MEMRD, E_IORD | E_TMO | aluc(4'b0010));
        // Fetch stall reaching the wait limit, then a fresh count in the re-entered FETCH.
        for (int i = 0; i < int'(WL) - 1; i++) step($sformatf("ftmo.wait%0d", i), S_FETCH,
                                                     fetch_wait);
        step("ftmo.pulse", S_FETCH, fetch_wait | E_TMO);
        step("ftmo.again", S_FETCH, fetch_wait);
        bus.mem_ready = 1'b1;
        step("ftmo.fetch", S_FETCH, fetch_ok);
        step("ftmo.decode", S_DECODE, dec);
        step("ftmo.memadr", S_MEMADR, E_SRCA | srcb(2'b10) | aluc(4'b0010));
        step("ftmo.memrd", S_MEMRD, E_IORD | aluc(4'b0010));
        step("ftmo.memwb", S_MEMWB, E_REGW | E_M2R | aluc(4'b0010));

        // Asynchronous reset in the middle of a stalled store.
        begin_instr("rsw", 6'b101011, 6'b000000, 1'b0);
        step("rsw.memadr", S_MEMADR, E_SRCA | srcb(2'b10) | aluc(4'b0010));
        bus.mem_ready = 1'b0;
        step("rsw.wait", S_MEMWR, E_IORD | E_MEMW | aluc(4'b0010));
        #2;
        check("rsw.pre_memwrite", 32'(bus.memwrite), 32'd1);
        reset = 1'b1;
        #1;
        check("rsw.memwrite", 32'(bus.memwrite), 32'd0);
        check("rsw.state", 32'(dut.state_q), 32'(S_FETCH));
        check("rsw.cnt", 32'(dut.wait_cnt_q), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rsw.rel_state", 32'(dut.state_q), 32'(S_FETCH));
        check("rsw.rel_cnt", 32'(dut.wait_cnt_q), 32'd0);
        bus.mem_ready = 1'b1;
        step("rsw.fetch", S_FETCH, fetch_ok);
        step("rsw.decode", S_DECODE, dec);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style control FSM that sequences the processor's shared-memory multicycle datapath: one instruction per 3–5 states, one memory port shared by fetch and load/store. It drives the register-file, ALU, extender and PC-select controls already defined for the datapath: ALU control codes, link, lbu/half/b load-width selects and jr. A `mem_ready` handshake stretches every memory state for slow memory.

## Interface
- `WAIT_LIMIT`, default 255: maximum cycles spent in one memory state before `mem_timeout` pulses.
- `clk  in  1`: single clock, rising edge.
- `reset  in  1`: asynchronous, active-high; state forced to FETCH.
- `op  in  6`: instr[31:26] from the instruction register.
- `funct  in  6`: instr[5:0].
- `zero  in  1`: ALU zero flag.
- `mem_ready  in  1`: memory completes the current access this cycle.
- `pcen  out  1`: PC register load enable.
- `irwrite  out  1`: instruction register load.
- `iord  out  1`: 0 = address from PC, 1 = from ALUOut.
- `memwrite  out  1`: memory write strobe.
- `regwrite  out  1`: register-file write.
- `memtoreg  out  1`: write-back from memory data.
- `regdst  out  1`: destination is rd (1) or rt (0).
- `link  out  1`: write PC+4 to r31.
- `lbu / half / b  out  1 each`: load-width selects (zero-extend byte, sign-extend half, sign-extend byte).
- `alusrca  out  1`: 0 = PC, 1 = rs.
- `alusrcb  out  2`: 00 rt, 01 constant 4, 10 extended immediate, 11 immediate<<2.
- `zeroext  out  1`: immediate zero-extended (andi/ori).
- `pcsrc  out  2`: 00 ALU result, 01 ALUOut, 10 jump target, 11 rs (jr).
- `alucontrol  out  4`: ALU operation.
- `mem_timeout  out  1`: one-cycle pulse on wait overflow.
- `illegal  out  1`: one-cycle pulse on an unknown op/funct in DECODE.

## Operation
- States:
  - FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR.
  - RTYPEEX, ALUWB, BRANCH, IMMEX, IMMWB.
  - JUMP, JAL, JR.
- FETCH:
  - iord=0, alusrca=0, alusrcb=01, ADD, pcsrc=00.
  - irwrite=pcen=mem_ready.
  - Advances to DECODE only when mem_ready=1.
- DECODE:
  - alusrcb=11, ADD (branch target into ALUOut).
  - Next state by op:
    - lw/lb/lbu/lh/sw → MEMADR.
    - R-type → RTYPEEX; R-type with funct 001000 (jr) → JR.
    - beq/bne → BRANCH.
    - addi/andi/ori/slti → IMMEX.
    - j → JUMP; jal → JAL.
    - Anything else → FETCH with illegal=1.
- MEMADR: alusrca=1, alusrcb=10, ADD. Next state MEMWR for sw, else MEMRD.
- MEMRD:
  - iord=1.
  - On mem_ready → MEMWB.
  - Width selects valid in MEMRD and MEMWB: lbu op 100100, half op 100001, b op 100000.
- MEMWB: regwrite=1, memtoreg=1, regdst=0 → FETCH.
- MEMWR: iord=1, memwrite=1. Stays until mem_ready, then → FETCH.
- RTYPEEX:
  - alusrca=1, alusrcb=00, alucontrol from funct:
    - add 100000→0010, sub 100010→0110, and 100100→0000, or 100101→0001.
    - slt 101010→0111, sll 000000→1000, srl 000010→1001.
  - → ALUWB.
- ALUWB: regwrite=1, regdst=1 → FETCH.
- BRANCH:
  - alusrca=1, alusrcb=00, SUB, pcsrc=01.
  - pcen = zero XOR (op==bne) → FETCH.
- IMMEX:
  - alusrca=1, alusrcb=10.
  - addi→ADD, andi→AND, ori→OR, slti→SLT; zeroext=1 for andi/ori.
  - → IMMWB.
- IMMWB: regwrite=1, regdst=0 → FETCH.
- JUMP: pcsrc=10, pcen=1 → FETCH.
- JAL: pcsrc=10, pcen=1, regwrite=1, link=1 → FETCH. PC+4 is the current PC, incremented in FETCH.
- JR: pcsrc=11, pcen=1 → FETCH.
- Every output not listed for a state is 0; alucontrol defaults to ADD (0010).

## Timing
- Reset:
  - State=FETCH; wait counter=0.
  - While reset=1, pcen/irwrite/memwrite/regwrite are forced 0.
  - Pulses are 0.
- Cycles with zero wait states: lw/lb/lbu/lh 5, sw 4, R-type 4, addi-class 4, beq/bne 3, j/jal/jr 3.
- Wait states:
  - Each memory state (FETCH, MEMRD, MEMWR) lasts 1+N cycles for N cycles of mem_ready=0.
  - memwrite stays high throughout MEMWR.
  - irwrite/pcen pulse only in the mem_ready cycle.
- Wait counter:
  - 8 bits, cleared on entry to any memory state, saturating.
  - When it reaches WAIT_LIMIT, mem_timeout pulses once and the FSM returns to FETCH, with PC unchanged unless the timeout occurs in FETCH.
- mem_ready is ignored outside memory states.
- Asynchronous reset mid-instruction abandons it. No write enable may glitch high on the reset edge.

## Structure
- Package `mc_pkg` holds:
  - the state enum;
  - opcode and funct localparams;
  - the 4-bit ALU control codes;
  - alusrcb/pcsrc encodings.
- Sub-module `alu_decoder`: combinational mapping from state class, op and funct to alucontrol.
- Remainder: one state register, one wait counter, one output-decode always_comb.

## Test plan
- Reset pulse, then op=lw with mem_ready=1 throughout:
  - state sequence FETCH→DECODE→MEMADR→MEMRD→MEMWB→FETCH;
  - regwrite=memtoreg=1 only in cycle 5.
- sw with mem_ready low for 3 cycles in MEMWR: memwrite high for exactly 4 cycles, then FETCH.
- Branches:
  - beq with zero=1 → pcen=1, pcsrc=01 in BRANCH;
  - bne with zero=1 → pcen=0.
- R-type funct 100010: alucontrol=0110 in RTYPEEX, regdst=1 in ALUWB. funct 001000 → JR with pcsrc=11.
- Errors:
  - op=111111 → illegal pulses once, next state FETCH, no write enable asserted;
  - mem_ready held 0 for WAIT_LIMIT cycles in MEMRD → mem_timeout single pulse.
- Reset asserted during MEMWR: memwrite falls asynchronously; after release, FETCH with counter=0.
